// File: rtl/param_fifo_fwft.sv
// param_fifo_fwft: parametrised synchronous FIFO, first-word-fall-through read.
// Register storage, occupancy count, level flags and sticky error flags.
module param_fifo_fwft #(
    parameter int depth            = 5,
    parameter int width            = 8,
    parameter int almostFullLevel  = 28,
    parameter int almostEmptyLevel = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] pushedValue,
    output logic [width-1:0] poppedValue,
    output logic             empty,
    output logic             full,
    output logic             almostEmpty,
    output logic             almostFull,
    output logic [depth:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int N = 2 ** depth;
    localparam logic [depth:0] FULL_CNT = {1'b1, {depth{1'b0}}};
    localparam logic [depth:0] AF_LVL   = (depth + 1)'(almostFullLevel);
    localparam logic [depth:0] AE_LVL   = (depth + 1)'(almostEmptyLevel);

    logic [width-1:0] mem_q [N];
    logic [depth-1:0] rdPtr_q, rdPtr_d;
    logic [depth-1:0] wrPtr_q, wrPtr_d;
    logic [depth:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             clear;
    logic             pushOk;
    logic             popOk;

    // Status decoded from registered count only, never from push/pop.
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign almostEmpty = (count_q <= AE_LVL);
    assign almostFull  = (count_q >= AF_LVL);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign poppedValue = empty ? '0 : mem_q[rdPtr_q];

    // Reset and flush both drop any request made in the same cycle.
    assign clear  = reset || flush;
    assign pushOk = !clear && push && (!full || pop);
    assign popOk  = !clear && pop && !empty;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (pushOk && !popOk) begin
                count_d = count_q + 1'b1;
            end else if (popOk && !pushOk) begin
                count_d = count_q - 1'b1;
            end
            if (push && !pushOk) begin
                overflow_d = 1'b1;
            end
            if (pop && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= pushedValue;
        end
    end

endmodule

// File: tb/tb_param_fifo_fwft.sv
// tb_param_fifo_fwft: directed bench for param_fifo_fwft.
// depth=3 (8 entries), width=8, almostFull at 6, almostEmpty at 1.
module tb_param_fifo_fwft;

    logic       clk = 1'b0;
    logic       reset, flush, push, pop;
    logic [7:0] pushedValue;
    logic [7:0] poppedValue;
    logic       empty, full, almostEmpty, almostFull;
    logic [3:0] count;
    logic       overflow, underflow;

    int total = 0;
    int bad   = 0;

    param_fifo_fwft #(
        .depth(3),
        .width(8),
        .almostFullLevel(6),
        .almostEmptyLevel(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .push(push),
        .pop(pop),
        .pushedValue(pushedValue),
        .poppedValue(poppedValue),
        .empty(empty),
        .full(full),
        .almostEmpty(almostEmpty),
        .almostFull(almostFull),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0;
        pop = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pushedValue = 8'h70 + 8'(i);
            tick();
        end
        reset = 1'b1;
        pop = 1'b1;
        tick();
        tick();
        idle();
        if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++;
        if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++;
        if (almostEmpty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", almostEmpty); end
        total++;
        if (almostFull !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", almostFull); end
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL rst_sticky got=%b%b exp=00", overflow, underflow);
        end
        total++;
        if (poppedValue !== 8'h00) begin bad++; $display("FAIL rst_pv got=%h exp=00", poppedValue); end
        total++;
    endtask

    task automatic test_fill();
        push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            pushedValue = 8'(i);
            tick();
            if (count !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            total++;
            if (almostEmpty !== (i <= 1)) begin
                bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almostEmpty, (i <= 1));
            end
            total++;
            if (almostFull !== (i >= 6)) begin
                bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almostFull, (i >= 6));
            end
            total++;
            if (full !== (i == 8)) begin
                bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 8));
            end
            total++;
            if (poppedValue !== 8'h01) begin
                bad++; $display("FAIL fill_front[%0d] got=%h exp=01", i, poppedValue);
            end
            total++;
        end
        pushedValue = 8'h09;
        tick();
        idle();
        if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++;
        if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_udf got=%b exp=0", underflow); end
        total++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b0;
            if (poppedValue !== 8'(i)) begin
                bad++; $display("FAIL drain_pv[%0d] got=%h exp=%h", i, poppedValue, 8'(i));
            end
            total++;
            pop = 1'b1;
            tick();
            if (count !== 4'(8 - i)) begin
                bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 8 - i);
            end
            total++;
        end
        pop = 1'b0;
        if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        total++;
        if (poppedValue !== 8'h00) begin bad++; $display("FAIL drain_pv0 got=%h exp=00", poppedValue); end
        total++;
        if (underflow !== 1'b0) begin bad++; $display("FAIL drain_udf0 got=%b exp=0", underflow); end
        total++;
        pop = 1'b1;
        tick();
        idle();
        if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", underflow); end
        total++;
        if (count !== 4'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", count); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        total++;
    endtask

    task automatic test_simultaneous();
        flush = 1'b1;
        tick();
        idle();
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL sim_clr got=%b%b exp=00", overflow, underflow);
        end
        total++;
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pushedValue = 8'h20 + 8'(i);
            tick();
        end
        pushedValue = 8'hAA;
        pop = 1'b1;
        tick();
        idle();
        if (count !== 4'd8) begin bad++; $display("FAIL fullpp_count got=%0d exp=8", count); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
        total++;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'hAA : 8'h21 + 8'(i);
            pop = 1'b0;
            if (poppedValue !== exp) begin
                bad++; $display("FAIL fullpp_pv[%0d] got=%h exp=%h", i, poppedValue, exp);
            end
            total++;
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        if (empty !== 1'b1) begin bad++; $display("FAIL fullpp_empty got=%b exp=1", empty); end
        total++;
        push = 1'b1;
        pop = 1'b1;
        pushedValue = 8'h55;
        tick();
        idle();
        if (count !== 4'd1) begin bad++; $display("FAIL emptypp_count got=%0d exp=1", count); end
        total++;
        if (poppedValue !== 8'h55) begin bad++; $display("FAIL emptypp_pv got=%h exp=55", poppedValue); end
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL emptypp_udf got=%b exp=1", underflow); end
        total++;
    endtask

    task automatic test_wrap();
        flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1;
            pushedValue = 8'h01 + 8'(i);
            tick();
        end
        push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop = 1'b0;
            if (poppedValue !== 8'h01 + 8'(i)) begin
                bad++; $display("FAIL wrapA_pv[%0d] got=%h exp=%h", i, poppedValue, 8'h01 + 8'(i));
            end
            total++;
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pushedValue = 8'h10 + 8'(i);
            tick();
        end
        push = 1'b0;
        if (count !== 4'd6) begin bad++; $display("FAIL wrap_count got=%0d exp=6", count); end
        total++;
        for (int i = 0; i < 6; i++) begin
            pop = 1'b0;
            if (poppedValue !== 8'h10 + 8'(i)) begin
                bad++; $display("FAIL wrapB_pv[%0d] got=%h exp=%h", i, poppedValue, 8'h10 + 8'(i));
            end
            total++;
            pop = 1'b1;
            tick();
            if (count !== 4'(5 - i)) begin
                bad++; $display("FAIL wrapB_count[%0d] got=%0d exp=%0d", i, count, 5 - i);
            end
            total++;
        end
        idle();
    endtask

    task automatic test_flush();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushedValue = 8'h30 + 8'(i);
            tick();
        end
        if (count !== 4'd4) begin bad++; $display("FAIL fl_pre_count got=%0d exp=4", count); end
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL fl_pre_udf got=%b exp=1", underflow); end
        total++;
        flush = 1'b1;
        pushedValue = 8'hEE;
        tick();
        idle();
        if (count !== 4'd0) begin bad++; $display("FAIL fl_count got=%0d exp=0", count); end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL fl_empty got=%b exp=1", empty); end
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL fl_sticky got=%b%b exp=00", overflow, underflow);
        end
        total++;
        if (poppedValue !== 8'h00) begin bad++; $display("FAIL fl_pv got=%h exp=00", poppedValue); end
        total++;
        tick();
        if (count !== 4'd0) begin bad++; $display("FAIL fl_hold got=%0d exp=0", count); end
        total++;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        pushedValue = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
